// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared types and constants for the multi-cycle sequencer
package ctrl_pkg;

    // Width of the memory wait timer shared by FETCH and MEM
    localparam int WAIT_CNT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        TRAP   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_ILLEGAL  = 2'd1,
        CAUSE_FETCH_TO = 2'd2,
        CAUSE_DATA_TO  = 2'd3
    } trap_cause_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - memory handshake, decode flags and control outputs of the sequencer
interface multicycle_ctrl_if #(
    parameter int CNT_WIDTH = 64
) ();
    logic                 imem_req;
    logic                 imem_ack;
    logic                 dmem_req;
    logic                 dmem_we;
    logic                 dmem_ack;
    logic                 is_load;
    logic                 is_store;
    logic                 need_wb;
    logic                 is_ebreak;
    logic                 inst_not_ipl;
    logic                 ir_we;
    logic                 rf_wen;
    logic                 pc_we;
    logic                 retire;
    logic                 halted;
    logic                 trap;
    logic [1:0]           trap_cause;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] instret;

    // Sequencer side
    modport master (
        output imem_req, dmem_req, dmem_we, ir_we, rf_wen, pc_we, retire,
        output halted, trap, trap_cause, state, instret,
        input  imem_ack, dmem_ack, is_load, is_store, need_wb, is_ebreak, inst_not_ipl
    );

    // Memory / datapath side
    modport slave (
        input  imem_req, dmem_req, dmem_we, ir_we, rf_wen, pc_we, retire,
        input  halted, trap, trap_cause, state, instret,
        output imem_ack, dmem_ack, is_load, is_store, need_wb, is_ebreak, inst_not_ipl
    );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// rtl/multicycle_ctrl_wait_timer.sv - memory ack wait counter with timeout detect
module wait_timer
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [WAIT_CNT_WIDTH-1:0] count;

    // Count unacknowledged wait cycles; any state change restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_CNT_WIDTH'(1);
        end
    end

    // Flag the cycle whose missing ack would bring the count up to TIMEOUT
    always_comb begin
        expired = enable && (count == WAIT_CNT_WIDTH'(TIMEOUT - 1));
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer with sticky halt and trap
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int CNT_WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);
    state_e               stateQ;
    state_e               nextState;
    trap_cause_e          causeQ;
    trap_cause_e          nextCause;
    logic                 haltedQ;
    logic                 trapQ;
    logic [CNT_WIDTH-1:0] instretQ;
    logic                 waitEn;
    logic                 waitExpired;
    logic                 stateChange;

    // Only unacknowledged cycles in the two memory wait states advance the timer
    always_comb begin
        waitEn = ((stateQ == FETCH) && !bus.imem_ack) ||
                 ((stateQ == MEM)   && !bus.dmem_ack);
    end

    assign stateChange = (stateQ != nextState);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (stateChange),
        .enable  (waitEn),
        .expired (waitExpired)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= nextState;
        end
    end

    // Next-state and control output decode; HALT/TRAP fall through to all-zero defaults
    always_comb begin
        nextState    = stateQ;
        nextCause    = CAUSE_NONE;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.ir_we    = 1'b0;
        bus.rf_wen   = 1'b0;
        bus.pc_we    = 1'b0;
        bus.retire   = 1'b0;
        case (stateQ)
            IDLE: begin
                nextState = FETCH;
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    bus.ir_we = 1'b1;
                    nextState = DECODE;
                end else if (waitExpired) begin
                    nextState = TRAP;
                    nextCause = CAUSE_FETCH_TO;
                end
            end
            DECODE: begin
                if (bus.inst_not_ipl) begin
                    nextState = TRAP;
                    nextCause = CAUSE_ILLEGAL;
                end else if (bus.is_ebreak) begin
                    nextState = HALT;
                end else begin
                    nextState = EXEC;
                end
            end
            EXEC: begin
                nextState = (bus.is_load || bus.is_store) ? MEM : WB;
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = bus.is_store;
                if (bus.dmem_ack) begin
                    nextState = WB;
                end else if (waitExpired) begin
                    nextState = TRAP;
                    nextCause = CAUSE_DATA_TO;
                end
            end
            WB: begin
                bus.rf_wen = bus.need_wb && !bus.is_store;
                bus.pc_we  = 1'b1;
                bus.retire = 1'b1;
                nextState  = FETCH;
            end
            default: begin
                nextState = stateQ;
            end
        endcase
    end

    // Sticky halt/trap flags; the cause is captured only on the edge entering TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haltedQ <= 1'b0;
            trapQ   <= 1'b0;
            causeQ  <= CAUSE_NONE;
        end else begin
            if (nextState == HALT && stateQ != HALT) begin
                haltedQ <= 1'b1;
            end
            if (nextState == TRAP && stateQ != TRAP) begin
                trapQ  <= 1'b1;
                causeQ <= nextCause;
            end
        end
    end

    // Retired-instruction counter, bumped alongside the WB retire pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instretQ <= '0;
        end else if (stateQ == WB) begin
            instretQ <= instretQ + CNT_WIDTH'(1);
        end
    end

    assign bus.halted     = haltedQ;
    assign bus.trap       = trapQ;
    assign bus.trap_cause = causeQ;
    assign bus.state      = stateQ;
    assign bus.instret    = instretQ;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   reqSeen;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_WIDTH(64)) bus ();

    multicycle_ctrl #(
        .TIMEOUT   (4),
        .CNT_WIDTH (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic setAcks(input logic ia, input logic da);
        bus.imem_ack = ia;
        bus.dmem_ack = da;
    endtask

    task automatic setFlags(input logic ld, input logic st, input logic wb,
                            input logic eb, input logic nip);
        bus.is_load      = ld;
        bus.is_store     = st;
        bus.need_wb      = wb;
        bus.is_ebreak    = eb;
        bus.inst_not_ipl = nip;
    endtask

    function automatic logic [6:0] ctl();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we,
                bus.rf_wen, bus.pc_we, bus.retire};
    endfunction

    task automatic doReset();
        rst = 1'b1;
        setAcks(1'b0, 1'b0);
        setFlags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_instret", bus.instret, 64'd0);
        chk("rst_flags", 64'({bus.halted, bus.trap, bus.trap_cause}), 64'd0);
        chk("rst_ctl", 64'(ctl()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Zero-wait ALU instruction
        doReset();
        tick();
        setAcks(1'b1, 1'b0);
        setFlags(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_fetch_state", 64'(bus.state), 64'd1);
        chk("alu_fetch_ctl", 64'(ctl()), 64'b1001000);
        tick();
        setAcks(1'b0, 1'b0);
        #1;
        chk("alu_decode_state", 64'(bus.state), 64'd2);
        chk("alu_decode_ctl", 64'(ctl()), 64'd0);
        tick();
        #1;
        chk("alu_exec_state", 64'(bus.state), 64'd3);
        tick();
        #1;
        chk("alu_wb_state", 64'(bus.state), 64'd5);
        chk("alu_wb_ctl", 64'(ctl()), 64'b0000111);
        chk("alu_wb_instret", bus.instret, 64'd0);
        tick();
        #1;
        chk("alu_done_state", 64'(bus.state), 64'd1);
        chk("alu_done_instret", bus.instret, 64'd1);

        // Load with dmem_ack on the 4th MEM cycle (coincides with timer limit)
        setAcks(1'b1, 1'b0);
        setFlags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        setAcks(1'b0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_mem_wait_state", 64'(bus.state), 64'd4);
            chk("ld_mem_wait_ctl", 64'(ctl()), 64'b0100000);
            tick();
        end
        setAcks(1'b0, 1'b1);
        #1;
        chk("ld_mem_ack_state", 64'(bus.state), 64'd4);
        chk("ld_mem_ack_ctl", 64'(ctl()), 64'b0100000);
        tick();
        setAcks(1'b0, 1'b0);
        #1;
        chk("ld_wb_state", 64'(bus.state), 64'd5);
        chk("ld_wb_ctl", 64'(ctl()), 64'b0000111);
        chk("ld_no_trap", 64'(bus.trap), 64'd0);
        tick();
        #1;
        chk("ld_instret", bus.instret, 64'd2);

        // Store with need_wb set must not write the register file
        setAcks(1'b1, 1'b0);
        setFlags(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        setAcks(1'b0, 1'b0);
        tick();
        tick();
        setAcks(1'b0, 1'b1);
        #1;
        chk("st_mem_ctl", 64'(ctl()), 64'b0110000);
        tick();
        setAcks(1'b0, 1'b0);
        #1;
        chk("st_wb_ctl", 64'(ctl()), 64'b0000011);
        tick();
        #1;
        chk("st_instret", bus.instret, 64'd3);

        // ebreak after three retirements
        setAcks(1'b1, 1'b0);
        setFlags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        setAcks(1'b0, 1'b0);
        #1;
        chk("eb_decode_state", 64'(bus.state), 64'd2);
        tick();
        #1;
        chk("eb_halt_state", 64'(bus.state), 64'd6);
        chk("eb_flags", 64'({bus.halted, bus.trap, bus.trap_cause}), 64'b1000);
        chk("eb_no_retire", 64'(bus.retire), 64'd0);
        chk("eb_instret", bus.instret, 64'd3);
        reqSeen = 0;
        setAcks(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.imem_req || bus.dmem_req) reqSeen++;
        end
        chk("eb_quiet", 64'(reqSeen), 64'd0);
        chk("eb_stays_halt", 64'(bus.state), 64'd6);

        // Illegal instruction outranks ebreak
        doReset();
        tick();
        setAcks(1'b1, 1'b0);
        setFlags(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        setAcks(1'b0, 1'b0);
        tick();
        #1;
        chk("ill_state", 64'(bus.state), 64'd7);
        chk("ill_flags", 64'({bus.halted, bus.trap, bus.trap_cause}), 64'b0101);
        reqSeen = 0;
        setAcks(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.imem_req) reqSeen++;
        end
        chk("ill_no_fetch", 64'(reqSeen), 64'd0);
        chk("ill_stays_trap", 64'(bus.state), 64'd7);

        // Fetch timeout after 4 unacknowledged FETCH cycles
        doReset();
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fto_wait_state", 64'(bus.state), 64'd1);
            tick();
        end
        #1;
        chk("fto_state", 64'(bus.state), 64'd7);
        chk("fto_cause", 64'(bus.trap_cause), 64'd2);

        // Ack in the 4th FETCH cycle beats the timeout
        doReset();
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            tick();
        end
        setAcks(1'b1, 1'b0);
        #1;
        chk("fack_ir_we", 64'(bus.ir_we), 64'd1);
        tick();
        setAcks(1'b0, 1'b0);
        setFlags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fack_state", 64'(bus.state), 64'd2);
        chk("fack_no_trap", 64'(bus.trap), 64'd0);

        // Data timeout on the same load
        tick();
        tick();
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("dto_state", 64'(bus.state), 64'd7);
        chk("dto_cause", 64'(bus.trap_cause), 64'd3);

        // Asynchronous reset in the middle of MEM
        doReset();
        tick();
        setAcks(1'b1, 1'b0);
        setFlags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        setAcks(1'b0, 1'b0);
        tick();
        tick();
        #1;
        chk("amr_in_mem", 64'(ctl()), 64'b0100000);
        rst = 1'b1;
        #1;
        chk("amr_state", 64'(bus.state), 64'd0);
        chk("amr_ctl", 64'(ctl()), 64'd0);
        chk("amr_instret", bus.instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        #1;
        chk("amr_refetch", 64'(bus.state), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the NPC core. It replaces the free-running single-cycle flow with an explicit FETCH → DECODE → EXECUTE → MEM → WB state machine. It gates the instruction-register load, register-file write enable and PC update, and handshakes with instruction and data memory. It also detects ebreak and unimplemented instructions, and memory timeouts, and parks the core in a sticky HALT or TRAP state that top-level DPI hooks can observe.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles to wait for a memory ack before trapping; 1..255.
- CNT_WIDTH, default 64: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  data access is a store.
- dmem_ack  in  1  data access complete this cycle.
- is_load  in  1  decoded instruction is a load.
- is_store  in  1  decoded instruction is a store.
- need_wb  in  1  decoded instruction writes rd.
- is_ebreak  in  1  decoded instruction is ebreak.
- inst_not_ipl  in  1  decoded instruction is unimplemented.
- ir_we  out  1  latch fetched instruction.
- rf_wen  out  1  register-file write enable.
- pc_we  out  1  advance PC to next_pc.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky, ebreak reached.
- trap  out  1  sticky, fault reached.
- trap_cause  out  2  0 none, 1 illegal instruction, 2 fetch timeout, 3 data timeout.
- state  out  3  current state encoding, for debug.
- instret  out  CNT_WIDTH  retired-instruction count.

## Operation
- States: IDLE(0), FETCH(1), DECODE(2), EXEC(3), MEM(4), WB(5), HALT(6), TRAP(7).
- Control outputs (imem_req, dmem_req, dmem_we, ir_we, rf_wen, pc_we, retire) are Moore/Mealy combinational from the state register. They are 0 in every state not listed below.
- IDLE: entered on reset; moves to FETCH on the first clock edge after rst deasserts.
- FETCH: imem_req=1.
  - imem_ack=1: ir_we=1, next state DECODE.
  - Otherwise wait.
- DECODE: one cycle. Priority order: inst_not_ipl → TRAP with cause 1; then is_ebreak → HALT; otherwise → EXEC.
- EXEC: one cycle. If is_load or is_store → MEM, otherwise → WB.
- MEM: dmem_req=1, dmem_we=is_store.
  - dmem_ack=1: next state WB.
  - Otherwise wait.
- WB: rf_wen=need_wb & ~is_store, pc_we=1, retire=1, instret increments by 1 (wraps modulo 2^CNT_WIDTH). Next state FETCH.
- HALT and TRAP are terminal: no requests are issued, all enables are 0, and only rst exits them.
- Wait timer: 8-bit counter, cleared on every state change. It increments each cycle spent in FETCH or MEM without an ack.
  - When it reaches TIMEOUT with no ack in that cycle → TRAP with cause 2 (FETCH) or 3 (MEM).
  - An ack in the same cycle the timer reaches TIMEOUT wins: normal transition, no trap.
- Acks arriving in any state other than FETCH or MEM are ignored.
- Decode inputs are sampled only in DECODE, EXEC, MEM and WB. The instruction register holds them stable from DECODE through WB.

## Timing
- Reset values: state=IDLE, instret=0, halted=0, trap=0, trap_cause=0, wait timer=0, all control outputs 0.
- rst asserted at any point (including mid-MEM) returns to IDLE immediately. No retire or write occurs for the interrupted instruction.
- Best-case latency with zero-wait memory:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
- halted and trap rise on the clock edge leaving DECODE (or the timed-out wait state) and stay high until reset.
- trap_cause is written only on entry to TRAP.
- Exactly one retire pulse per WB. retire and the instret increment occur in the same cycle.

## Structure
- Shared package ctrl_pkg holds:
  - state_e, a 3-bit enum with the encodings above;
  - trap_cause_e, a 2-bit enum;
  - WAIT_CNT_WIDTH = 8.
- Sub-module wait_timer: clear, enable and TIMEOUT compare, with an expired output. It is instantiated once, shared by FETCH and MEM.
- FSM, output decode and instret counter live in multicycle_ctrl.

## Test plan
- Zero-wait ALU instruction: imem_ack high in FETCH, all decode flags 0, need_wb=1 → ir_we in cycle 1, rf_wen, pc_we and retire in cycle 4, instret=1.
- Load with dmem_ack delayed 3 cycles → dmem_req held 4 cycles, dmem_we=0, WB on the cycle after ack, 8 cycles total. Store with need_wb=1 → rf_wen=0.
- DECODE with inst_not_ipl=1 and is_ebreak=1 together → TRAP, trap_cause=1, halted=0. No further imem_req over 20 cycles.
- TIMEOUT=4, imem_ack never asserts → TRAP, cause 2, after 4 FETCH cycles. Repeat with ack in the 4th cycle → DECODE, no trap.
- rst asserted mid-MEM → state=IDLE asynchronously, dmem_req drops the same cycle, instret unchanged. Release rst → FETCH on the next edge.
- 3 retirements followed by ebreak → instret=3, halted=1, state=6, no retire pulse for the ebreak.
